// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
// Purpose : shared constants for the RV64 multi-cycle sequencer: 5-bit major
//           opcodes (inst[6:2]), sequencer state encoding, PC-select and
//           trap-cause encodings, and the legal-opcode check used by DECODE.
// Ports   : none (package)
// ----------------------------------------------------------------------------
package core_pkg;

  localparam logic [4:0] OP_LOAD      = 5'b00000;
  localparam logic [4:0] OP_MISC_MEM  = 5'b00011;
  localparam logic [4:0] OP_OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC     = 5'b00101;
  localparam logic [4:0] OP_OP_IMM_32 = 5'b00110;
  localparam logic [4:0] OP_STORE     = 5'b01000;
  localparam logic [4:0] OP_AMO       = 5'b01011;
  localparam logic [4:0] OP_OP        = 5'b01100;
  localparam logic [4:0] OP_LUI       = 5'b01101;
  localparam logic [4:0] OP_OP_32     = 5'b01110;
  localparam logic [4:0] OP_BRANCH    = 5'b11000;
  localparam logic [4:0] OP_JALR      = 5'b11001;
  localparam logic [4:0] OP_JAL       = 5'b11011;
  localparam logic [4:0] OP_SYSTEM    = 5'b11100;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_DECODE,
    S_EXECUTE,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_WRITEBACK,
    S_TRAP
  } state_e;

  typedef enum logic [1:0] {
    PC_SEL_SEQ    = 2'd0,
    PC_SEL_TARGET = 2'd1,
    PC_SEL_TRAP   = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    CAUSE_ILLEGAL   = 2'd0,
    CAUSE_FETCH_ERR = 2'd1,
    CAUSE_ECALL     = 2'd2
  } trap_cause_e;

  // Legal = 32-bit encoding (inst[1:0]==11) and one of the 14 base+A major opcodes.
  function automatic logic is_legal(input logic [31:0] inst);
    logic ok;
    case (inst[6:2])
      OP_LOAD, OP_MISC_MEM, OP_OP_IMM, OP_AUIPC, OP_OP_IMM_32, OP_STORE, OP_AMO,
      OP_OP, OP_LUI, OP_OP_32, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok && (inst[1:0] == 2'b11);
  endfunction

endpackage

// File: rtl/core_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// core_seq_ctrl_if
// Purpose : bundles the imem/dmem handshakes, datapath strobes and trap
//           signals of the sequencer. Signal names keep the sequencer's
//           direction prefix (o_ = driven by the sequencer).
// Modports: master - the sequencer (core_seq_ctrl)
//           slave  - buses / datapath / trap handler side
// ----------------------------------------------------------------------------
interface core_seq_ctrl_if #(
  parameter int XLEN = 64
);
  logic            o_imem_req_valid;
  logic            i_imem_req_ready;
  logic            i_imem_rsp_valid;
  logic [31:0]     i_imem_rsp_data;
  logic [31:0]     o_inst;
  logic            o_dmem_req_valid;
  logic            o_dmem_we;
  logic            i_dmem_req_ready;
  logic            i_dmem_rsp_valid;
  logic            i_branch_taken;
  logic            o_rf_we;
  logic            o_pc_we;
  logic [1:0]      o_pc_sel;
  logic            o_retire;
  logic [XLEN-1:0] o_instret;
  logic            o_trap;
  logic [1:0]      o_trap_cause;
  logic            i_trap_ack;

  modport master (
    output o_imem_req_valid, o_inst, o_dmem_req_valid, o_dmem_we, o_rf_we,
           o_pc_we, o_pc_sel, o_retire, o_instret, o_trap, o_trap_cause,
    input  i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data, i_dmem_req_ready,
           i_dmem_rsp_valid, i_branch_taken, i_trap_ack
  );

  modport slave (
    input  o_imem_req_valid, o_inst, o_dmem_req_valid, o_dmem_we, o_rf_we,
           o_pc_we, o_pc_sel, o_retire, o_instret, o_trap, o_trap_cause,
    output i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data, i_dmem_req_ready,
           i_dmem_rsp_valid, i_branch_taken, i_trap_ack
  );
endinterface

// File: rtl/core_instret_ctr.sv
// ----------------------------------------------------------------------------
// core_instret_ctr
// Purpose : XLEN-bit retired-instruction counter, wraps at 2^XLEN.
// Ports   : i_clk   clock, rising edge
//           i_rst   asynchronous active-high reset (count -> 0)
//           i_inc   add one this cycle
//           o_count current count
// ----------------------------------------------------------------------------
module core_instret_ctr #(
  parameter int XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_inc,
  output logic [XLEN-1:0] o_count
);
  logic [XLEN-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_count <= '0;
    else if (i_inc) r_count <= r_count + XLEN'(1);
  end

  assign o_count = r_count;
endmodule

// File: rtl/core_seq_ctrl.sv
// ----------------------------------------------------------------------------
// core_seq_ctrl
// Purpose : multi-cycle fetch/decode/execute/mem/writeback sequencer for the
//           RV64 core. Holds the IR, the fetch timeout counter and the trap
//           cause; raises PC/RF write strobes, memory handshakes and retire.
// Ports   : i_clk  clock, rising edge
//           i_rst  asynchronous active-high reset
//           bus    core_seq_ctrl_if.master (imem/dmem handshakes, IR, PC/RF
//                  strobes, retire/instret, trap/cause/ack)
// Params  : XLEN (instret width), FETCH_TIMEOUT (1..255 cycles in FETCH_WAIT)
// Config  : ILLEGAL_TRAP_EN defined  -> illegal insn traps with cause 0
//           undefined (default)      -> illegal insn retires as a NOP
//
// state        | meaning
// S_FETCH_REQ  | imem request raised, wait for ready
// S_FETCH_WAIT | wait for imem response, timeout counter running
// S_DECODE     | legality / SYSTEM check on IR
// S_EXECUTE    | sample branch result, pick mem or writeback
// S_MEM_REQ    | dmem request raised, wait for ready
// S_MEM_WAIT   | wait for dmem response
// S_WRITEBACK  | PC/RF strobes, retire
// S_TRAP       | trap raised, wait for ack
// ----------------------------------------------------------------------------
module core_seq_ctrl
  import core_pkg::*;
#(
  parameter int XLEN          = 64,
  parameter int FETCH_TIMEOUT = 255
) (
  input  logic           i_clk,
  input  logic           i_rst,
  core_seq_ctrl_if.master bus
);
  localparam logic [7:0] TO_LAST = 8'(FETCH_TIMEOUT - 1);

  state_e      r_state, w_state_nxt;
  trap_cause_e r_cause, w_cause_nxt;
  logic [31:0] r_inst;
  logic [7:0]  r_cnt;
  logic        r_taken;

  logic        w_imem_req, w_dmem_req, w_dmem_we, w_rf_we, w_pc_we, w_retire, w_trap;
  pc_sel_e     w_pc_sel;
  logic [XLEN-1:0] w_instret;

  logic [4:0]  w_op;
  logic        w_legal, w_is_mem, w_mem_we, w_wr_rd, w_pc_tgt;

  assign w_op     = r_inst[6:2];
  assign w_legal  = is_legal(r_inst);
  assign w_is_mem = (w_op == OP_LOAD) || (w_op == OP_STORE) || (w_op == OP_AMO);
  assign w_mem_we = (w_op == OP_STORE) || (w_op == OP_AMO);
  // Illegal insns only reach WRITEBACK in the non-trapping build, where they act as NOPs.
  assign w_wr_rd  = w_legal && (r_inst[11:7] != 5'd0) &&
                    !((w_op == OP_STORE) || (w_op == OP_BRANCH) || (w_op == OP_MISC_MEM));
  assign w_pc_tgt = w_legal && ((w_op == OP_JAL) || (w_op == OP_JALR) ||
                                ((w_op == OP_BRANCH) && r_taken));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_FETCH_REQ;
      r_cause <= CAUSE_ILLEGAL;
      r_inst  <= INST_NOP;
      r_cnt   <= 8'd0;
      r_taken <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cause <= w_cause_nxt;
      if (r_state == S_FETCH_REQ) r_cnt <= 8'd0;
      else if (r_state == S_FETCH_WAIT) r_cnt <= r_cnt + 8'd1;
      if ((r_state == S_FETCH_WAIT) && bus.i_imem_rsp_valid) r_inst <= bus.i_imem_rsp_data;
      if (r_state == S_EXECUTE) r_taken <= bus.i_branch_taken;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    w_imem_req  = 1'b0;
    w_dmem_req  = 1'b0;
    w_dmem_we   = 1'b0;
    w_rf_we     = 1'b0;
    w_pc_we     = 1'b0;
    w_pc_sel    = PC_SEL_SEQ;
    w_retire    = 1'b0;
    w_trap      = 1'b0;
    case (r_state)
      S_FETCH_REQ: begin
        w_imem_req = 1'b1;
        if (bus.i_imem_req_ready) w_state_nxt = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        // A response arriving on the last allowed cycle still wins over the timeout.
        if (bus.i_imem_rsp_valid) w_state_nxt = S_DECODE;
        else if (r_cnt == TO_LAST) begin
          w_state_nxt = S_TRAP;
          w_cause_nxt = CAUSE_FETCH_ERR;
        end
      end
      S_DECODE: begin
        if (!w_legal) begin
`ifdef ILLEGAL_TRAP_EN
          w_state_nxt = S_TRAP;
          w_cause_nxt = CAUSE_ILLEGAL;
`else
          w_state_nxt = S_WRITEBACK;
`endif
        end else if (w_op == OP_SYSTEM) begin
          w_state_nxt = S_TRAP;
          w_cause_nxt = CAUSE_ECALL;
        end else begin
          w_state_nxt = S_EXECUTE;
        end
      end
      S_EXECUTE: w_state_nxt = w_is_mem ? S_MEM_REQ : S_WRITEBACK;
      S_MEM_REQ: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = w_mem_we;
        if (bus.i_dmem_req_ready) w_state_nxt = S_MEM_WAIT;
      end
      S_MEM_WAIT: if (bus.i_dmem_rsp_valid) w_state_nxt = S_WRITEBACK;
      S_WRITEBACK: begin
        w_pc_we     = 1'b1;
        w_retire    = 1'b1;
        w_rf_we     = w_wr_rd;
        w_pc_sel    = w_pc_tgt ? PC_SEL_TARGET : PC_SEL_SEQ;
        w_state_nxt = S_FETCH_REQ;
      end
      S_TRAP: begin
        w_trap = 1'b1;
        if (bus.i_trap_ack) begin
          w_pc_we     = 1'b1;
          w_pc_sel    = PC_SEL_TRAP;
          w_state_nxt = S_FETCH_REQ;
        end
      end
      default: w_state_nxt = S_FETCH_REQ;
    endcase
  end

  core_instret_ctr #(.XLEN(XLEN)) u_instret (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (w_retire),
    .o_count (w_instret)
  );

  // The reset state is FETCH_REQ, but no fetch may be requested while reset is held.
  assign bus.o_imem_req_valid = w_imem_req & ~i_rst;
  assign bus.o_dmem_req_valid = w_dmem_req;
  assign bus.o_dmem_we        = w_dmem_we;
  assign bus.o_inst           = r_inst;
  assign bus.o_rf_we          = w_rf_we;
  assign bus.o_pc_we          = w_pc_we;
  assign bus.o_pc_sel         = w_pc_sel;
  assign bus.o_retire         = w_retire;
  assign bus.o_instret        = w_instret;
  assign bus.o_trap           = w_trap;
  assign bus.o_trap_cause     = w_trap ? r_cause : CAUSE_ILLEGAL;
endmodule

// File: tb/tb_core_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_core_seq_ctrl
// Purpose : directed bench for core_seq_ctrl. A cycle schedule of inputs and
//           expected outputs is built up front from instruction-level timing
//           rules; one compare process checks every cycle, plus literal pins.
// ----------------------------------------------------------------------------
module tb_core_seq_ctrl;
  localparam int T_OUT = 255;
  localparam int N     = 2048;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic        rst, ireq_rdy, irsp_v;
    logic [31:0] idata;
    logic        dreq_rdy, drsp_v, taken, ack;
  } stim_t;

  typedef struct packed {
    logic        ireq, dreq, dwe, rfwe, pcwe;
    logic [1:0]  pcsel;
    logic        ret, trap;
    logic [1:0]  cause;
    logic [31:0] inst;
    logic [63:0] instret;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  core_seq_ctrl_if #(.XLEN(64)) bus ();
  core_seq_ctrl #(.XLEN(64), .FETCH_TIMEOUT(T_OUT)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;

  stim_t       stim [N];
  exp_t        expv [N];
  exp_t        ce;
  int          t = 0, n_plan = 0, cyc = 0, last_acc = 0;
  int          n_chk = 0, n_fail = 0;
  int          s_addi = 0, s_amo = 0, acc_to = 0;
  bit          seen_addi = 0, seen_amo = 0, seen_to = 0, g_stale = 0;
  logic [31:0] m_inst;
  logic [63:0] m_instret;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit legal_op(input logic [31:0] x);
    logic [4:0] o;
    o = x[6:2];
    return (x[1:0] == 2'b11) && (o inside {5'h00, 5'h03, 5'h04, 5'h05, 5'h06, 5'h08, 5'h0B,
                                           5'h0C, 5'h0D, 5'h0E, 5'h18, 5'h19, 5'h1B, 5'h1C});
  endfunction

  task automatic emit(input stim_t s, input exp_t e);
    e.inst    = m_inst;
    e.instret = m_instret;
    stim[t]   = s;
    expv[t]   = e;
    t++;
  endtask

  task automatic reset_cyc(input int n, input bit stale);
    stim_t s; exp_t e;
    m_inst = 32'h0000_0013; m_instret = 64'd0;
    for (int i = 0; i < n; i++) begin
      s = '0; e = '0; s.rst = 1'b1;
      if (stale) begin s.irsp_v = 1'b1; s.drsp_v = 1'b1; s.idata = 32'h1234_5673; end
      emit(s, e);
    end
  endtask

  task automatic idle(input int n);
    stim_t s; exp_t e;
    for (int i = 0; i < n; i++) begin s = '0; e = '0; e.ireq = 1'b1; emit(s, e); end
  endtask

  task automatic trap(input logic [1:0] cause, input int ad);
    stim_t s; exp_t e;
    for (int i = 0; i <= ad; i++) begin
      s = '0; e = '0; e.trap = 1'b1; e.cause = cause; s.ack = (i == ad);
      if (i == ad) begin e.pcwe = 1'b1; e.pcsel = 2'd2; end
      emit(s, e);
    end
  endtask

  // fd/rdly: imem ready/rsp delay; md/mrd: dmem ready/rsp delay; rdly<0: no imem response.
  task automatic run_insn(input logic [31:0] inst, input int fd, input int rdly,
                          input int md, input int mrd, input bit taken, input int ad,
                          input bit abort);
    stim_t s; exp_t e;
    logic [4:0] op;
    bit lg, ismem, we, wrd, tgt;
    op    = inst[6:2];
    lg    = legal_op(inst);
    ismem = (op == 5'h00) || (op == 5'h08) || (op == 5'h0B);
    we    = (op == 5'h08) || (op == 5'h0B);
    wrd   = !((op == 5'h08) || (op == 5'h18) || (op == 5'h03)) && (inst[11:7] != 5'd0);
    tgt   = (op == 5'h1B) || (op == 5'h19) || ((op == 5'h18) && taken);
    for (int i = 0; i <= fd; i++) begin
      s = '0; e = '0; s.taken = !taken; e.ireq = 1'b1; s.ireq_rdy = (i == fd);
      if (g_stale && i < fd) begin
        s.irsp_v = 1'b1; s.drsp_v = 1'b1; s.idata = 32'hBAD0_0003 | (i << 8);
      end
      emit(s, e);
    end
    last_acc = t - 1;
    if (rdly < 0) begin
      for (int i = 0; i < T_OUT; i++) begin s = '0; e = '0; s.idata = 32'hFFFF_FFFF; emit(s, e); end
      trap(2'd1, ad);
      return;
    end
    for (int i = 0; i <= rdly; i++) begin
      s = '0; e = '0; s.taken = !taken;
      s.irsp_v = (i == rdly);
      s.idata  = (i == rdly) ? inst : 32'h0BAD_0013;
      emit(s, e);
    end
    m_inst = inst;
    s = '0; e = '0; s.taken = !taken; emit(s, e);          // decode
    if (lg && op == 5'h1C) begin trap(2'd2, ad); return; end
    if (!lg && TRAP_EN) begin trap(2'd0, ad); return; end
    if (lg) begin
      s = '0; e = '0; s.taken = taken; emit(s, e);         // execute
      if (ismem) begin
        for (int i = 0; i <= md; i++) begin
          s = '0; e = '0; s.taken = !taken; e.dreq = 1'b1; e.dwe = we; s.dreq_rdy = (i == md);
          emit(s, e);
        end
        if (abort) begin
          s = '0; e = '0; emit(s, e); emit(s, e);
          return;
        end
        for (int i = 0; i <= mrd; i++) begin
          s = '0; e = '0; s.taken = !taken; s.drsp_v = (i == mrd); emit(s, e);
        end
      end
    end
    s = '0; e = '0; s.taken = !taken;
    e.pcwe = 1'b1; e.ret = 1'b1; e.rfwe = lg && wrd; e.pcsel = (lg && tgt) ? 2'd1 : 2'd0;
    emit(s, e);
    m_instret = m_instret + 64'd1;
  endtask

  task automatic apply(input stim_t s);
    rst                  = s.rst;
    bus.i_imem_req_ready = s.ireq_rdy;
    bus.i_imem_rsp_valid = s.irsp_v;
    bus.i_imem_rsp_data  = s.idata;
    bus.i_dmem_req_ready = s.dreq_rdy;
    bus.i_dmem_rsp_valid = s.drsp_v;
    bus.i_branch_taken   = s.taken;
    bus.i_trap_ack       = s.ack;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h, expected %h", nm, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0 && cyc < n_plan) begin
      ce = expv[cyc];
      chk("imem_req_valid", 64'(bus.o_imem_req_valid), 64'(ce.ireq));
      chk("dmem_req_valid", 64'(bus.o_dmem_req_valid), 64'(ce.dreq));
      chk("dmem_we",        64'(bus.o_dmem_we),        64'(ce.dwe));
      chk("rf_we",          64'(bus.o_rf_we),          64'(ce.rfwe));
      chk("pc_we",          64'(bus.o_pc_we),          64'(ce.pcwe));
      chk("pc_sel",         64'(bus.o_pc_sel),         64'(ce.pcsel));
      chk("retire",         64'(bus.o_retire),         64'(ce.ret));
      chk("trap",           64'(bus.o_trap),           64'(ce.trap));
      chk("trap_cause",     64'(bus.o_trap_cause),     64'(ce.cause));
      chk("inst",           64'(bus.o_inst),           64'(ce.inst));
      chk("instret",        bus.o_instret,             ce.instret);
      if (cyc >= s_addi && !seen_addi && bus.o_retire) begin
        seen_addi = 1'b1;
        chk("addi_latency", 64'(cyc - s_addi), 64'd4);
      end
      if (cyc == s_addi + 5) chk("addi_instret_pin", bus.o_instret, 64'd1);
      if (cyc >= s_amo && !seen_amo && bus.o_retire) begin
        seen_amo = 1'b1;
        chk("amo_latency", 64'(cyc - s_amo), 64'd6);
      end
      if (cyc > acc_to && !seen_to && bus.o_trap) begin
        seen_to = 1'b1;
        chk("timeout_latency", 64'(cyc - acc_to), 64'd256);
        chk("timeout_cause_pin", 64'(bus.o_trap_cause), 64'd1);
      end
      if (cyc == n_plan - 1) begin
        chk("final_instret_pin", bus.o_instret, 64'd1);
        chk("final_inst_pin", 64'(bus.o_inst), 64'h0010_0093);
      end
    end
  end

  initial begin
    reset_cyc(2, 1'b0);
    s_addi = t;
    run_insn(32'h0010_0093, 0, 0, 0, 0, 1'b0, 0, 1'b0);  // ADDI x1, zero wait
    run_insn(32'h0000_2103, 1, 1, 3, 1, 1'b0, 0, 1'b0);  // LW x2, dmem ready +3
    run_insn(32'h0020_2023, 0, 2, 3, 0, 1'b0, 0, 1'b0);  // SW x2, dmem ready +3
    s_amo = t;
    run_insn(32'h0020_21AF, 0, 0, 0, 0, 1'b0, 0, 1'b0);  // AMOADD.W x3, zero wait
    run_insn(32'h0000_0063, 0, 0, 0, 0, 1'b1, 0, 1'b0);  // BEQ taken
    run_insn(32'h0000_0063, 0, 1, 0, 0, 1'b0, 0, 1'b0);  // BEQ not taken
    run_insn(32'h0000_00EF, 2, 0, 0, 0, 1'b0, 0, 1'b0);  // JAL x1
    run_insn(32'h0000_000F, 0, 0, 0, 0, 1'b0, 0, 1'b0);  // FENCE
    run_insn(32'h0000_0013, 0, 0, 0, 0, 1'b0, 0, 1'b0);  // ADDI x0 (rd=0)
    run_insn(32'hFFFF_FFFF, 0, 0, 0, 0, 1'b0, 2, 1'b0);  // illegal
    run_insn(32'h0000_0000, 0, 0, 0, 0, 1'b0, 1, 1'b0);  // illegal, low bits 00
    run_insn(32'h0000_0073, 0, 0, 0, 0, 1'b0, 1, 1'b0);  // ECALL
    run_insn(32'h0010_0093, 1, -1, 0, 0, 1'b0, 3, 1'b0); // imem never responds
    acc_to = last_acc;
    run_insn(32'h0010_0093, 0, 0, 0, 0, 1'b0, 0, 1'b0);  // recovery after trap
    run_insn(32'h0000_2103, 0, 0, 1, 5, 1'b0, 0, 1'b1);  // LW, abandoned in MEM_WAIT
    reset_cyc(3, 1'b1);
    g_stale = 1'b1;
    run_insn(32'h0010_0093, 2, 0, 0, 0, 1'b0, 0, 1'b0);  // ADDI after reset, stale rsp first
    g_stale = 1'b0;
    idle(3);
    n_plan = t;

    apply(stim[0]);
    for (int k = 1; k < n_plan; k++) begin
      @(posedge clk); #1;
      apply(stim[k]);
    end
    @(posedge clk); #1;
    chk("addi_retire_seen", 64'(seen_addi), 64'd1);
    chk("amo_retire_seen", 64'(seen_amo), 64'd1);
    chk("timeout_trap_seen", 64'(seen_to), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
